// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// mem_arbiter : round-robin sequencer sharing one 64-bit memory port between
//               instruction fetch (I) and load/store (D); optional ARB_ABORT_EN
//               adds an iabort input that cancels an in-flight I access.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int N   = 64,
  parameter int LAT = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ireq,
  input  logic [31:0]  iadr,
  output logic         igrant,
  output logic         ivalid,
  output logic [31:0]  irdata,
  input  logic         dreq,
  input  logic [1:0]   dwe,
  input  logic [N-1:0] dadr,
  input  logic [N-1:0] dwdata,
  output logic         dgrant,
  output logic         dvalid,
  output logic [N-1:0] drdata,
  output logic [1:0]   m_memwrite,
  output logic [N-1:0] m_adr,
  output logic [N-1:0] m_wdata,
  input  logic [N-1:0] m_rdata,
`ifdef ARB_ABORT_EN
  input  logic         iabort,
`endif
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [2:0] CNT_INIT = 3'(LAT - 1);

  state_t     state;
  logic [2:0] cnt;
  logic       last_d;   // side granted most recently (1 = D)
  logic       is_d;     // side owning the current access
  logic       d_wr;     // current D access is a write

`ifdef ARB_ABORT_EN
  logic abort_now;
  assign abort_now = !is_d && iabort;
`else
  logic abort_now;
  assign abort_now = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 3'd0;
      last_d     <= 1'b0;
      is_d       <= 1'b0;
      d_wr       <= 1'b0;
      igrant     <= 1'b0;
      ivalid     <= 1'b0;
      dgrant     <= 1'b0;
      dvalid     <= 1'b0;
      busy       <= 1'b0;
      m_memwrite <= 2'd0;
      irdata     <= 32'd0;
      drdata     <= '0;
      m_adr      <= '0;
      m_wdata    <= '0;
    end else begin
      igrant     <= 1'b0;
      dgrant     <= 1'b0;
      ivalid     <= 1'b0;
      dvalid     <= 1'b0;
      m_memwrite <= 2'd0;
      case (state)
        IDLE: begin
          // D wins when alone, or on a conflict when I had the last turn
          if (dreq && (!ireq || !last_d)) begin
            dgrant     <= 1'b1;
            is_d       <= 1'b1;
            last_d     <= 1'b1;
            d_wr       <= (dwe != 2'd0);
            m_adr      <= dadr;
            m_wdata    <= dwdata;
            m_memwrite <= dwe;
            cnt        <= CNT_INIT;
            busy       <= 1'b1;
            state      <= ACCESS;
          end else if (ireq) begin
            igrant     <= 1'b1;
            is_d       <= 1'b0;
            last_d     <= 1'b0;
            d_wr       <= 1'b0;
            m_adr      <= N'(iadr);
            cnt        <= CNT_INIT;
            busy       <= 1'b1;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          if (abort_now) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (cnt == 3'd0) begin
            if (!is_d)
              irdata <= m_adr[2] ? m_rdata[31:0] : m_rdata[N-1 -: 32];
            else if (!d_wr)
              drdata <= m_rdata;
            state <= RESP;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        RESP: begin
          if (is_d)
            dvalid <= 1'b1;
          else
            ivalid <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
